// File: rtl/apophis_pkg.sv
// Shared constants and FSM encodings for the drive-wheel
// encoder path (period meter, apply_force).
package apophis_pkg;

  localparam logic [19:0] MAX_PERIOD   = 20'h7FFFF;
  localparam logic [19:0] PERIOD_2MPH  = 20'h01496;
  localparam logic [19:0] PERIOD_10MPH = 20'h0041E;
  localparam int          EDGES_PER_REV = 400;
  localparam int          FILT_CYCLES  = 8;
  localparam int          AVG_LOG2     = 2;

  typedef enum logic [1:0] {
    STALL = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2
  } meter_state_e;

endpackage

// File: rtl/input_deglitch.sv
// Synchronises an async input, accepts a level change only after
// FILT_CYCLES stable samples, and flags filtered rising edges.
module input_deglitch #(
  parameter int FILT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_level,
  output logic o_edge
);

  localparam int CW = $clog2(FILT_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_edge;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_done;

  assign w_diff = (r_s2 != r_level);
  assign w_done = w_diff &&
                  (r_cnt == CW'(FILT_CYCLES - 1));

  // two-flop synchroniser
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_in;
      r_s2 <= r_s1;
    end
  end

  // stability counter; any sample matching the level restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_edge <= w_done & r_s2;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt   <= '0;
        r_level <= r_s2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_edge  = r_edge;

endmodule

// File: rtl/encoder_period_meter.sv
// Times filtered encoder rising edges and reports a 4-tap moving
// average of the interval, or MAX_PERIOD while the wheel is stopped.
module encoder_period_meter #(
  parameter logic [19:0] MAX_PERIOD = apophis_pkg::MAX_PERIOD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_in,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        stalled
);

  import apophis_pkg::*;

  localparam int NTAP = 1 << AVG_LOG2;
  localparam int SW   = 20 + AVG_LOG2;

  meter_state_e        r_state;
  logic [19:0]         r_cnt;
  logic [19:0]         r_ring [NTAP];
  logic [AVG_LOG2-1:0] r_ptr;
  logic [SW-1:0]       r_sum;
  logic [19:0]         r_period;
  logic                r_valid;
  logic                r_stalled;

  logic                w_level;
  logic                w_edge_raw;
  logic                w_edge;
  logic                w_timeout;
  logic                w_stall_go;
  logic [SW-1:0]       w_sum_next;

  input_deglitch #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_deglitch (
    .clk    (clk),
    .rst    (rst),
    .i_in   (enc_in),
    .o_level(w_level),
    .o_edge (w_edge_raw)
  );

  // edge is only ever flagged together with a high level
  assign w_edge     = w_edge_raw & w_level;
  assign w_timeout  = (r_cnt == MAX_PERIOD);
  assign w_stall_go = (r_state != STALL) &&
                      !w_edge && w_timeout;
  // sum always contains the oldest entry, so no underflow
  assign w_sum_next = r_sum + SW'(r_cnt) -
                      SW'(r_ring[r_ptr]);

  // interval counter: restarts at 1 on each edge, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_edge) begin
      r_cnt <= 20'd1;
    end else if (!w_timeout) begin
      r_cnt <= r_cnt + 20'd1;
    end
  end

  // STALL/ARM/RUN sequencing with ring buffer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= STALL;
      for (int i = 0; i < NTAP; i++) r_ring[i] <= MAX_PERIOD;
      r_ptr     <= '0;
      r_sum     <= SW'(MAX_PERIOD) << AVG_LOG2;
      r_period  <= MAX_PERIOD;
      r_valid   <= 1'b0;
      r_stalled <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      if (w_stall_go) begin
        r_state   <= STALL;
        for (int i = 0; i < NTAP; i++) r_ring[i] <= MAX_PERIOD;
        r_ptr     <= '0;
        r_sum     <= SW'(MAX_PERIOD) << AVG_LOG2;
        r_period  <= MAX_PERIOD;
        r_valid   <= 1'b1;
        r_stalled <= 1'b1;
      end else begin
        unique case (r_state)
          STALL: begin
            if (w_edge) r_state <= ARM;
          end
          ARM: begin
            if (w_edge) begin
              r_state   <= RUN;
              for (int i = 0; i < NTAP; i++) r_ring[i] <= r_cnt;
              r_ptr     <= '0;
              r_sum     <= SW'(r_cnt) << AVG_LOG2;
              r_period  <= r_cnt;
              r_valid   <= 1'b1;
              r_stalled <= 1'b0;
            end
          end
          RUN: begin
            if (w_edge) begin
              r_ring[r_ptr] <= r_cnt;
              r_ptr    <= r_ptr + AVG_LOG2'(1);
              r_sum    <= w_sum_next;
              r_period <= w_sum_next[SW-1:AVG_LOG2];
              r_valid  <= 1'b1;
            end
          end
          default: r_state <= STALL;
        endcase
      end
    end
  end

  assign period       = {12'h000, r_period};
  assign period_valid = r_valid;
  assign stalled      = r_stalled;

endmodule

// File: doc/encoder_period_meter.md
Name: encoder_period_meter

Overview:
Measures the drive-wheel encoder pulse interval and produces the `period` word consumed by the force-application stage (apply_force) to compute its commutation timing.
- Units: system clock cycles per encoder rising edge (400 edges/rev). At a 50 MHz clock, 2 mph gives 5270 and 10 mph gives 1054.
- Sits between the encoder input pin and apply_force.
- Stages: synchronises and deglitches the input, times successive edges, smooths them with a 4-tap moving average, and reports 0x7FFFF when the wheel is stopped.

Parameters:
- MAX_PERIOD, 20'h7FFFF, saturation/stall value; also the timeout threshold in clocks.
- FILT_CYCLES, 8, consecutive stable synchronised samples required to accept an input level change.
- AVG_LOG2, 2, log2 of moving-average depth (4 taps).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enc_in  in  1  raw encoder channel, asynchronous to clk
- period  out  32  averaged interval in clk cycles, zero-extended from 20 bits, range 1..MAX_PERIOD
- period_valid  out  1  one-cycle strobe on every period update, including stall entry
- stalled  out  1  high while no valid interval is available

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately. Reset values:
  - period = MAX_PERIOD, period_valid = 0, stalled = 1
  - sync/filter state = 0, FSM = STALL, interval counter = 0, ring buffer = MAX_PERIOD
- Input path:
  - 2-FF synchroniser on enc_in.
  - Filtered level changes only after FILT_CYCLES consecutive identical synchronised samples. Shorter pulses are ignored entirely.
  - Rising edge of the filtered level produces a one-cycle `edge` pulse.
  - Latency from enc_in rising to `edge` = 2 + FILT_CYCLES clocks (±1 for sampling phase).
- Interval counter:
  - Cleared to 1 on the `edge` cycle; increments by 1 each clock otherwise; saturates at MAX_PERIOD.
  - Value captured at an `edge` equals the exact clock count between the two accepted edges.
- FSM states: STALL, ARM, RUN.
  - STALL: on `edge` -> ARM; start counter. No output update, because the partial interval is meaningless.
  - ARM: on `edge` -> RUN. Captured interval S is written into all 2^AVG_LOG2 ring entries (preload). Output period = S.
  - RUN: on `edge`, S overwrites the oldest entry. Running sum updated as sum + S - oldest. Output = sum >> AVG_LOG2, truncating.
  - ARM or RUN, counter reaches MAX_PERIOD with no edge -> STALL. Then period = MAX_PERIOD, ring entries reset to MAX_PERIOD, stalled = 1, period_valid pulses once.
- Timing: period, period_valid and stalled all update on the clock after the `edge`/timeout cycle (1-cycle latency). stalled falls together with the first RUN update.
- Simultaneous events:
  - `edge` on the same cycle the counter hits MAX_PERIOD: edge wins; treat it as a valid interval of MAX_PERIOD.
  - `edge` while in STALL never updates period.
- Width rules:
  - Ring entries are 20 bits; the sum is 20 + AVG_LOG2 bits and never overflows.
  - period[31:20] is always 0.
- Reset mid-measurement discards all history. The bench must not see a stale period after rst deasserts.

Decomposition:
Shared package (apophis_pkg), one definition per constant:
- MAX_PERIOD = 20'h7FFFF
- PERIOD_2MPH = 20'h01496
- PERIOD_10MPH = 20'h0041E
- EDGES_PER_REV = 400
- FSM state encodings STALL / ARM / RUN

apply_force uses the same MAX_PERIOD constant.

Sub-module: input_deglitch, containing the 2-FF synchroniser, FILT_CYCLES stability counter and rising-edge detector. Outputs `level` and `edge`. It is reusable for a second encoder channel.

Test Plan:
- Reset defaults: assert rst, release, no encoder edges -> period = 0x7FFFF, stalled = 1, period_valid never pulses.
- Steady 2 mph: square wave on enc_in, 5270-clk period -> first update after the 2nd edge, period = 5270, stalled = 0; every later edge yields 5270 with a period_valid pulse.
- Speed step: after steady 5270, switch to 1054-clk period -> successive outputs 4216, 3162, 2108, 1054, then 1054 steady.
- Glitch rejection: inject 3-clk high pulses between edges at 5270 -> period stays 5270; no extra period_valid.
- Stop/stall: at steady 1054, hold enc_in low -> exactly 0x7FFFF clks after the last edge (+1), period = 0x7FFFF, stalled = 1, one period_valid pulse. Resume at 5270 -> first update = 5270 (preload, no blending with stale values).
- Reset mid-run: assert rst asynchronously between edges at 1054 -> period = 0x7FFFF immediately. After release, the first two edges behave as STALL -> ARM -> RUN.
